// File: rtl/axi_lite_cmd_master_if.sv
// Command/response handshake plus AXI4-Lite master channels for axi_lite_cmd_master.
// The master modport is the initiator's view; slave is the bus/consumer view.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_wstrb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [1:0]            rsp_resp;

  logic [ADDR_W-1:0]     m00_axi_awaddr;
  logic [2:0]            m00_axi_awprot;
  logic                  m00_axi_awvalid;
  logic                  m00_axi_awready;
  logic [DATA_W-1:0]     m00_axi_wdata;
  logic [DATA_W/8-1:0]   m00_axi_wstrb;
  logic                  m00_axi_wvalid;
  logic                  m00_axi_wready;
  logic [1:0]            m00_axi_bresp;
  logic                  m00_axi_bvalid;
  logic                  m00_axi_bready;
  logic [ADDR_W-1:0]     m00_axi_araddr;
  logic [2:0]            m00_axi_arprot;
  logic                  m00_axi_arvalid;
  logic                  m00_axi_arready;
  logic [DATA_W-1:0]     m00_axi_rdata;
  logic [1:0]            m00_axi_rresp;
  logic                  m00_axi_rvalid;
  logic                  m00_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot, rsp_ready,
           m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
           m00_axi_arready, m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
           m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid, m00_axi_bready,
           m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid, m00_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot, rsp_ready,
           m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
           m00_axi_arready, m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
           m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid, m00_axi_bready,
           m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid, m00_axi_rready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one response out.
// IDLE accept cmd | WR_REQ AW/W pending | WR_RESP wait B | RD_REQ AR pending | RD_DATA wait R | RESP hold result
module axi_lite_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input logic                   m00_axi_aclk,
  input logic                   m00_axi_aresetn,
  axi_lite_cmd_master_if.master bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [2:0]      prot_q, prot_d;
  logic            write_q, write_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      write_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
      write_q     <= write_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;
    write_d     = write_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        // cmd_ready comes up one edge after reset release
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
          wstrb_d     = bus.cmd_wstrb;
          prot_d      = bus.cmd_prot;
          write_d     = bus.cmd_write;
          if (bus.cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && bus.m00_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.m00_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bready_q && bus.m00_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = '0;
          rsp_resp_d  = bus.m00_axi_bresp;
          state_d     = RESP;
        end
      end
      RD_REQ: begin
        if (arvalid_q && bus.m00_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready_q && bus.m00_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = bus.m00_axi_rdata;
          rsp_resp_d  = bus.m00_axi_rresp;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_write       = rsp_write_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_resp        = rsp_resp_q;
  assign bus.m00_axi_awaddr  = addr_q;
  assign bus.m00_axi_awprot  = prot_q;
  assign bus.m00_axi_awvalid = awvalid_q;
  assign bus.m00_axi_wdata   = wdata_q;
  assign bus.m00_axi_wstrb   = wstrb_q;
  assign bus.m00_axi_wvalid  = wvalid_q;
  assign bus.m00_axi_bready  = bready_q;
  assign bus.m00_axi_araddr  = addr_q;
  assign bus.m00_axi_arprot  = prot_q;
  assign bus.m00_axi_arvalid = arvalid_q;
  assign bus.m00_axi_rready  = rready_q;
endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI4-Lite initiator that turns single-beat register commands into AXI4-Lite write or read transactions.
- It is the master-side counterpart of the slave register files in our IP (e.g. joystick registers).
- It sits between PL control logic (game FSM, pollers) and the AXI interconnect.
- Exactly one transaction is outstanding at a time; the result returns on a response port.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width.
C_M_AXI_DATA_WIDTH, 32, AXI data width (32 only; WSTRB width = DATA_WIDTH/8).

Ports:
m00_axi_aclk  in  1  clock; everything is sampled on the rising edge.
m00_axi_aresetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  byte address.
cmd_wdata  in  DATA_WIDTH  write data.
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
cmd_prot  in  3  driven onto AWPROT/ARPROT.
rsp_valid  out  1  result present.
rsp_ready  in  1  consumer accepts the result.
rsp_write  out  1  copy of cmd_write for this result.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
rsp_resp  out  2  captured BRESP or RRESP.
m00_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_WIDTH/3/1/1  AW channel.
m00_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel.
m00_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
m00_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_WIDTH/3/1/1  AR channel.
m00_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  R channel.

Behaviour:
- Clock and reset: one clock, m00_axi_aclk. Reset m00_axi_aresetn is asynchronous, active-low. All outputs are registered.
- Reset values: every output is 0, including cmd_ready; state = IDLE.
- cmd_ready rises on the first clock edge after reset release.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- IDLE (cmd_ready=1):
  - On cmd_valid&cmd_ready: latch addr/wdata/wstrb/prot/write and drop cmd_ready.
  - Write: go to WR_REQ with awvalid=wvalid=1 on the next cycle.
  - Read: go to RD_REQ with arvalid=1 on the next cycle.
  - Command-accept to first VALID latency is 1 cycle.
- WR_REQ:
  - awvalid and wvalid each deassert independently, the cycle after their own handshake.
  - Either may complete first, or both in the same cycle.
  - When both are done, go to WR_RESP with bready=1.
- WR_RESP:
  - On bvalid&bready: capture bresp, set rsp_rdata=0, drop bready, go to RESP.
- RD_REQ:
  - On arvalid&arready: drop arvalid, set rready=1, go to RD_DATA.
- RD_DATA:
  - On rvalid&rready: capture rdata/rresp, drop rready, go to RESP.
- RESP:
  - rsp_valid=1; rsp fields are stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE, cmd_ready=1 on the same edge.
  - Minimum command-to-command spacing: write 4 cycles, read 4 cycles, with zero-wait slave and rsp_ready=1.
- AXI rules:
  - A VALID, once asserted, is never dropped before its handshake.
  - addr/data/strb/prot are stable while VALID is high.
  - bready and rready are never asserted outside WR_RESP and RD_DATA.
- Response pass-through: SLVERR/DECERR (2'b10/2'b11) are passed to rsp_resp unmodified. No retry, no timeout.
- Command inputs are ignored whenever cmd_ready=0.
- Reset mid-transaction:
  - All VALID/READY outputs go to 0 immediately (asynchronous).
  - The pending command and its response are discarded.
  - The interconnect is reset on the same reset net.

Test Plan:
- Write 0x0101FFFF, wstrb 0xF, to base+0x0; slave awready/wready after 2 cycles, bvalid with OKAY 3 cycles later. Required: one AW beat and one W beat; rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Read base+0x4; slave returns 0xABCD0001 with OKAY. Required: rsp_rdata=0xABCD0001, rsp_resp=00, arvalid held high until arready.
- Write with wready 3 cycles before awready, then repeat with awready first, then same-cycle handshakes. Required: each VALID drops exactly one cycle after its own handshake; bready rises only after both are done.
- Read where the slave returns rresp=2'b10 with data 0xDEAD0011, and rsp_ready is held low for 5 cycles. Required: rsp_valid and fields stable for those 5 cycles; rsp_resp=10; cmd_ready=1 the cycle after rsp_ready.
- Back-to-back four-write/four-read sequence 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 at +4 strides against a register slave. Required: every readback matches and only one transaction is ever outstanding.
- Assert reset while in WR_RESP with bvalid pending. Required: all outputs 0 without waiting for a clock edge; after release, cmd_ready=1 one edge later and a new read completes normally.
